// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and
// the signed-overflow helper used by the add/sub path.
package ula_pkg;

    localparam int OP_ADD  = 1;
    localparam int OP_ADDI = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_SUBI = 4;
    localparam int OP_MUL  = 5;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_e;

    // sb is the effective sign of the second operand (already inverted
    // for subtraction).
    function automatic logic add_ovf(input logic sa,
                                     input logic sb,
                                     input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/ula_seq_if.sv
// Request/response bundle of the sequential ALU.
// master: decode side (drives operands, opcode, out_ready).
// slave:  ALU side (drives in_ready, result and flags).
interface ula_seq_if #(
    parameter int WIDTH = 16,
    parameter int OP_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [OP_W-1:0]  param;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] S_hi;
    logic             zero;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, A, B, param, out_ready,
        input  in_ready, out_valid, S, S_hi, zero, ovf, err
    );

    modport slave (
        input  in_valid, A, B, param, out_ready,
        output in_ready, out_valid, S, S_hi, zero, ovf, err
    );
endinterface

// File: rtl/ula_mul_seq.sv
// Iterative unsigned shift-add multiplier, one step per cycle.
// Ports: clk_i, rst_i, start_i, a_i/b_i magnitudes, busy_o, done_o, prod_o.
module ula_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_d;
    logic               last;

    // Multiplier sits in the low half and is consumed LSB first while
    // partial sums enter the high half; the carry is shifted back in.
    assign sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_d = {sum, prod_q[WIDTH-1:1]};
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));

    // The final product is offered during the last step so the caller
    // can register it on the same edge the step completes.
    assign busy_o = busy_q;
    assign done_o = busy_q && last;
    assign prod_o = prod_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= a_i;
            prod_q  <= {{WIDTH{1'b0}}, b_i};
        end else if (busy_q) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + 1'b1;
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/ula_seq.sv
// Sequential ALU: ADD/ADDI/SUB/SUBI in one cycle, signed MUL over WIDTH steps.
// Ports: clk, rst (sync, active high), bus (ula_seq_if slave).
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 3
) (
    input  logic      clk,
    input  logic      rst,
    ula_seq_if.slave  bus
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [WIDTH-1:0]   s_hi_q, s_hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               neg_q, neg_d;

    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   add_r, sub_r;

    assign bus.in_ready  = (state_q == IDLE) && !mul_busy;
    assign bus.out_valid = (state_q == DONE);
    assign bus.S         = s_q;
    assign bus.S_hi      = s_hi_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign mul_start = accept && (bus.param == OP_W'(OP_MUL));

    // Magnitude of the most negative value wraps to itself, which is
    // the correct unsigned magnitude.
    assign mag_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign mag_b = bus.B[WIDTH-1] ? -bus.B : bus.B;
    assign add_r = bus.A + bus.B;
    assign sub_r = bus.A - bus.B;

    assign prod_s = neg_q ? -mul_prod : mul_prod;

    ula_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(mul_start),
        .a_i    (mag_a),
        .b_i    (mag_b),
        .busy_o (mul_busy),
        .done_o (mul_done),
        .prod_o (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            s_hi_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            s_hi_q  <= s_hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        s_hi_d  = s_hi_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DONE;
                    case (bus.param)
                        OP_W'(OP_ADD), OP_W'(OP_ADDI): begin
                            s_d    = add_r;
                            s_hi_d = {WIDTH{add_r[WIDTH-1]}};
                            zero_d = (add_r == '0);
                            ovf_d  = add_ovf(bus.A[WIDTH-1], bus.B[WIDTH-1],
                                             add_r[WIDTH-1]);
                            err_d  = 1'b0;
                        end
                        OP_W'(OP_SUB), OP_W'(OP_SUBI): begin
                            s_d    = sub_r;
                            s_hi_d = {WIDTH{sub_r[WIDTH-1]}};
                            zero_d = (sub_r == '0);
                            ovf_d  = add_ovf(bus.A[WIDTH-1], ~bus.B[WIDTH-1],
                                             sub_r[WIDTH-1]);
                            err_d  = 1'b0;
                        end
                        OP_W'(OP_MUL): begin
                            neg_d   = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                            state_d = MUL;
                        end
                        default: begin
                            s_d    = '0;
                            s_hi_d = '0;
                            zero_d = 1'b1;
                            ovf_d  = 1'b0;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                if (mul_done) begin
                    s_d     = prod_s[WIDTH-1:0];
                    s_hi_d  = prod_s[2*WIDTH-1:WIDTH];
                    zero_d  = (prod_s == '0);
                    ovf_d   = (prod_s[2*WIDTH-1:WIDTH]
                               != {WIDTH{prod_s[WIDTH-1]}});
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: table of single operations plus
// backpressure, mid-multiply reset and busy-ignore sequences.
module tb_ula_seq;
    localparam int W = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] s;
        logic [15:0] hi;
        logic        z;
        logic        o;
        logic        e;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    vec_t vecs[15];

    always #5 clk = ~clk;

    ula_seq_if #(.WIDTH(W), .OP_W(3)) bus ();

    ula_seq #(.WIDTH(W), .OP_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else
            passed++;
    endtask

    // Called just after a clock edge; returns cycles from accept to out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, output int lat);
        bus.A        = a;
        bus.B        = b;
        bus.param    = op;
        bus.in_valid = 1'b1;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int nres;

        vecs[0]  = '{16'd100,  16'hFFE2, 3'b001, 16'h0046, 16'h0000, 0, 0, 0, 1};
        vecs[1]  = '{16'd32767, 16'd1,   3'b001, 16'h8000, 16'hFFFF, 0, 1, 0, 1};
        vecs[2]  = '{16'hFFFB, 16'd7,    3'b011, 16'hFFF4, 16'hFFFF, 0, 0, 0, 1};
        vecs[3]  = '{16'd9,    16'd9,    3'b100, 16'h0000, 16'h0000, 1, 0, 0, 1};
        vecs[4]  = '{16'hFFFF, 16'hFFFF, 3'b010, 16'hFFFE, 16'hFFFF, 0, 0, 0, 1};
        vecs[5]  = '{16'h8000, 16'd1,    3'b011, 16'h7FFF, 16'h0000, 0, 1, 0, 1};
        vecs[6]  = '{16'hFED4, 16'h00C8, 3'b101, 16'h15A0, 16'hFFFF, 0, 1, 0, 17};
        vecs[7]  = '{16'h8000, 16'hFFFF, 3'b101, 16'h8000, 16'h0000, 0, 1, 0, 17};
        vecs[8]  = '{16'd12,   16'hFFFD, 3'b101, 16'hFFDC, 16'hFFFF, 0, 0, 0, 17};
        vecs[9]  = '{16'd0,    16'hFFFB, 3'b101, 16'h0000, 16'h0000, 1, 0, 0, 17};
        vecs[10] = '{16'd181,  16'd181,  3'b101, 16'h7FF9, 16'h0000, 0, 0, 0, 17};
        vecs[11] = '{16'h8000, 16'h8000, 3'b101, 16'h0000, 16'h4000, 0, 1, 0, 17};
        vecs[12] = '{16'd5,    16'd6,    3'b000, 16'h0000, 16'h0000, 1, 0, 1, 1};
        vecs[13] = '{16'd5,    16'd6,    3'b111, 16'h0000, 16'h0000, 1, 0, 1, 1};
        vecs[14] = '{16'hFFFF, 16'd1,    3'b110, 16'h0000, 16'h0000, 1, 0, 1, 1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.param     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_S", 32'(bus.S), 32'd0);
        check("rst_S_hi", 32'(bus.S_hi), 32'd0);
        check("rst_flags", {29'd0, bus.zero, bus.ovf, bus.err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_S", i), 32'(bus.S), 32'(vecs[i].s));
            check($sformatf("v%0d_S_hi", i), 32'(bus.S_hi), 32'(vecs[i].hi));
            check($sformatf("v%0d_zero", i), 32'(bus.zero), 32'(vecs[i].z));
            check($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].o));
            check($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].e));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ack", i), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure after a multiply: 7 * -8 = -56
        bus.out_ready = 1'b0;
        run_op(16'd7, 16'hFFF8, 3'b101, lat);
        check("bp_lat", 32'(lat), 32'd17);
        check("bp_S", 32'(bus.S), 32'h0000FFC8);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_S", 32'(bus.S), 32'h0000FFC8);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of a multiply
        bus.A        = 16'd3;
        bus.B        = 16'd5;
        bus.param    = 3'b101;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        nres = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) nres++;
        end
        check("mid_rst_no_result", 32'(nres), 32'd0);
        run_op(16'd1, 16'd1, 3'b001, lat);
        check("post_rst_lat", 32'(lat), 32'd1);
        check("post_rst_S", 32'(bus.S), 32'd2);
        @(posedge clk);
        #1;

        // in_valid pulsed while multiplying is ignored: 2 * 3 = 6
        bus.A        = 16'd2;
        bus.B        = 16'd3;
        bus.param    = 3'b101;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.A        = 16'd100;
        bus.B        = 16'd100;
        bus.param    = 3'b001;
        check("pulse_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 2;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("pulse_lat", 32'(lat), 32'd17);
        check("pulse_S", 32'(bus.S), 32'd6);
        nres = bus.out_valid ? 1 : 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) nres++;
        end
        check("pulse_one_result", 32'(nres), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
